barrel_shift_left_pipe: RTL and testbench

- Pipelined logical left barrel shifter; the left-direction counterpart of the team's combinational ones-fill right shifter.
- Shifts a WIDTH-bit word left by 0..2^SAMT_W-1. The vacated LSBs are filled with a per-transaction fill bit: 1 gives the ones-fill mirror of the right shifter, 0 gives a plain SLL.
- One registered stage per shift-amount bit, with a valid/ready handshake on both sides. Sits in the datapath beside the right shifter, feeding the result mux.

---
 rtl/barrel_shift_left_pipe_pkg.sv | 12 +
 rtl/barrel_shift_left_pipe_shl_stage.sv | 48 ++++
 rtl/barrel_shift_left_pipe.sv | 63 ++++++
 tb/tb_barrel_shift_left_pipe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_shift_left_pipe_pkg.sv
// rtl/barrel_shift_left_pipe_pkg.sv - shared widths and stage-distance helper for the barrel shifters
package barrel_shift_left_pipe_pkg;

    localparam int WIDTH_DEFAULT  = 64;
    localparam int SAMT_W_DEFAULT = 5;

    // Stage k handles the most significant remaining shift-amount bit, so distances shrink down the pipe.
    function automatic int stage_dist(input int samt_w, input int k);
        return 1 << (samt_w - 1 - k);
    endfunction

endpackage

// File: rtl/barrel_shift_left_pipe_shl_stage.sv
// rtl/barrel_shift_left_pipe_shl_stage.sv - one registered left-shift stage of fixed distance
module shl_stage
    import barrel_shift_left_pipe_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEFAULT,
    parameter int SAMT_W = SAMT_W_DEFAULT,
    parameter int DIST   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              prev_valid,
    input  logic [WIDTH-1:0]  prev_data,
    input  logic [SAMT_W-1:0] prev_samt,
    input  logic              prev_fill,
    output logic              valid,
    output logic [WIDTH-1:0]  data,
    output logic [SAMT_W-1:0] samt,
    output logic              fill
);

    localparam int SEL = $clog2(DIST);

    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = prev_data;
        if (prev_samt[SEL]) begin
            shifted = {prev_data[WIDTH-1-DIST:0], {DIST{prev_fill}}};
        end
    end

    // Data moves even for bubbles; only the valid bit distinguishes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            samt  <= '0;
            fill  <= 1'b0;
        end else if (en) begin
            valid <= prev_valid;
            data  <= shifted;
            samt  <= prev_samt;
            fill  <= prev_fill;
        end
    end

endmodule

// File: rtl/barrel_shift_left_pipe.sv
// rtl/barrel_shift_left_pipe.sv - pipelined left barrel shifter with selectable fill and valid/ready
module barrel_shift_left_pipe
    import barrel_shift_left_pipe_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEFAULT,
    parameter int SAMT_W = SAMT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  D_in,
    input  logic [SAMT_W-1:0] samt,
    input  logic              fill,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  D_out
);

    // Index 0 is the input side; index k+1 is the register set of stage k.
    logic              v [SAMT_W+1];
    logic [WIDTH-1:0]  d [SAMT_W+1];
    logic [SAMT_W-1:0] s [SAMT_W+1];
    logic              f [SAMT_W+1];

    logic advance;
    logic unused_tail;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    assign v[0] = in_valid;
    assign d[0] = D_in;
    assign s[0] = samt;
    assign f[0] = fill;

    for (genvar k = 0; k < SAMT_W; k++) begin : g_stage
        shl_stage #(
            .WIDTH  (WIDTH),
            .SAMT_W (SAMT_W),
            .DIST   (stage_dist(SAMT_W, k))
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .en         (advance),
            .prev_valid (v[k]),
            .prev_data  (d[k]),
            .prev_samt  (s[k]),
            .prev_fill  (f[k]),
            .valid      (v[k+1]),
            .data       (d[k+1]),
            .samt       (s[k+1]),
            .fill       (f[k+1])
        );
    end

    assign out_valid = v[SAMT_W];
    assign D_out     = d[SAMT_W];

    // The last stage's shift amount and fill have no consumer.
    assign unused_tail = ^{s[SAMT_W], f[SAMT_W]};

endmodule

// File: tb/tb_barrel_shift_left_pipe.sv
// tb/tb_barrel_shift_left_pipe.sv - randomized self-checking bench for barrel_shift_left_pipe
module tb_barrel_shift_left_pipe;

    localparam int WIDTH  = 64;
    localparam int SAMT_W = 5;
    localparam int LAT    = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  D_in;
    logic [SAMT_W-1:0] samt;
    logic              fill;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  D_out;

    int errors = 0;
    int checks = 0;
    logic [WIDTH-1:0] exp_q [$];

    barrel_shift_left_pipe #(.WIDTH(WIDTH), .SAMT_W(SAMT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .D_in      (D_in),
        .samt      (samt),
        .fill      (fill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D_out     (D_out)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] din, input int sh, input logic fb);
        logic [WIDTH-1:0] mask;
        mask = (64'd1 << sh) - 64'd1;
        return (din << sh) | (fb ? mask : 64'd0);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; D_in = '1; samt = '1; fill = 1'b1; out_ready = 1'b0;
        next_cycle();
        next_cycle();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++;
        if (D_out !== 64'd0) begin errors++; $display("FAIL reset_d_out got=%h want=0", D_out); end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        in_valid = 1'b1; D_in = 64'h1; samt = 5'd5; fill = 1'b0;
        next_cycle();
        in_valid = 1'b0;
        for (int c = 1; c < LAT; c++) begin
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid cycle=%0d got=%b want=0", c, out_valid); end
            next_cycle();
        end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b want=1", out_valid); end
        checks++;
        if (D_out !== 64'h20) begin errors++; $display("FAIL basic_data got=%h want=%h", D_out, 64'h20); end
        next_cycle();
    endtask

    task automatic test_ones_fill();
        out_ready = 1'b1;
        in_valid = 1'b1; D_in = 64'h0123_4567_89AB_CDEF; samt = 5'd31; fill = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        repeat (LAT - 1) next_cycle();
        checks++;
        if (out_valid !== 1'b1 || D_out !== 64'hC4D5_E6F7_FFFF_FFFF)
        begin errors++; $display("FAIL ones_fill got v=%b d=%h want v=1 d=%h", out_valid, D_out, 64'hC4D5_E6F7_FFFF_FFFF); end
        next_cycle();
    endtask

    task automatic test_streaming();
        logic [WIDTH-1:0] want [8];
        want = '{64'd1, 64'd4, 64'd12, 64'd32, 64'd80, 64'd192, 64'd448, 64'd1024};
        out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            in_valid = (c < 8);
            D_in = 64'(c + 1); samt = 5'(c); fill = 1'b0;
            #1;
            checks++;
            if (c >= LAT && c < LAT + 8) begin
                if (out_valid !== 1'b1 || D_out !== want[c-LAT])
                begin errors++; $display("FAIL stream_item%0d got v=%b d=%0d want v=1 d=%0d", c-LAT, out_valid, D_out, want[c-LAT]); end
            end else if (out_valid !== 1'b0) begin
                errors++; $display("FAIL stream_idle cycle=%0d got v=%b want 0", c, out_valid);
            end
            next_cycle();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] held;
        int got;
        exp_q.delete();
        out_ready = 1'b0;
        for (int c = 0; c < LAT; c++) begin
            in_valid = 1'b1; D_in = {$urandom, $urandom}; samt = 5'($urandom); fill = 1'($urandom);
            #1;
            if (in_valid && in_ready) exp_q.push_back(model(D_in, int'(samt), fill));
            next_cycle();
        end
        in_valid = 1'b0;
        held = D_out;
        checks++;
        if (held !== exp_q[0]) begin errors++; $display("FAIL bp_head got=%h want=%h", held, exp_q[0]); end
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; D_in = {$urandom, $urandom};
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || D_out !== held)
            begin errors++; $display("FAIL bp_stall cycle=%0d got rdy=%b v=%b d=%h want rdy=0 v=1 d=%h", c, in_ready, out_valid, D_out, held); end
            next_cycle();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_extra got=%h want none", D_out);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = exp_q.pop_front();
                    if (D_out !== e) begin errors++; $display("FAIL bp_order got=%h want=%h", D_out, e); end
                end
                got++;
            end
            next_cycle();
        end
        checks++;
        if (got != 5) begin errors++; $display("FAIL bp_count got=%0d want=5", got); end
    endtask

    task automatic test_bubbles();
        int n_in;
        exp_q.delete();
        out_ready = 1'b1;
        n_in = 40;
        for (int c = 0; c < n_in + 8; c++) begin
            in_valid = (c < n_in) && (c % 2 == 0);
            D_in = {$urandom, $urandom}; samt = 5'($urandom); fill = 1'($urandom);
            #1;
            checks++;
            if (out_valid !== ((c >= LAT) && (c - LAT < n_in) && ((c - LAT) % 2 == 0)))
            begin errors++; $display("FAIL bubble_pattern cycle=%0d got v=%b", c, out_valid); end
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bubble_extra got=%h want none", D_out);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = exp_q.pop_front();
                    if (D_out !== e) begin errors++; $display("FAIL bubble_data got=%h want=%h", D_out, e); end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(D_in, int'(samt), fill));
            next_cycle();
        end
        in_valid = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL bubble_leftover got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_random_flow();
        int sent;
        exp_q.delete();
        sent = 0;
        for (int c = 0; c < 300; c++) begin
            in_valid = (sent < 100) && ($urandom_range(0, 3) != 0);
            out_ready = (c >= 250) || ($urandom_range(0, 2) != 0);
            D_in = {$urandom, $urandom}; samt = 5'($urandom); fill = 1'($urandom);
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL flow_extra got=%h want none", D_out);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = exp_q.pop_front();
                    if (D_out !== e) begin errors++; $display("FAIL flow_data got=%h want=%h", D_out, e); end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(D_in, int'(samt), fill));
                sent++;
            end
            next_cycle();
        end
        in_valid = 1'b0;
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0)
        begin errors++; $display("FAIL flow_drain got left=%0d v=%b want 0/0", exp_q.size(), out_valid); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; D_in = {$urandom, $urandom} | 64'h1; samt = 5'(c); fill = 1'b1;
            next_cycle();
        end
        rst = 1'b1; in_valid = 1'b1;
        next_cycle();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || D_out !== 64'd0)
        begin errors++; $display("FAIL midrst_clear got v=%b d=%h want v=0 d=0", out_valid, D_out); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b want=1", in_ready); end
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale cycle=%0d got v=%b d=%h", c, out_valid, D_out); end
        end
        in_valid = 1'b1; D_in = 64'h8000_0000_0000_00F0; samt = 5'd3; fill = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        for (int c = 1; c < LAT; c++) begin
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_early cycle=%0d got v=%b", c, out_valid); end
            next_cycle();
        end
        checks++;
        if (out_valid !== 1'b1 || D_out !== 64'h0000_0000_0000_0787)
        begin errors++; $display("FAIL midrst_first got v=%b d=%h want v=1 d=%h", out_valid, D_out, 64'h787); end
        next_cycle();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_ones_fill();
        test_streaming();
        test_backpressure();
        test_bubbles();
        test_random_flow();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
